alu_chain_seq: RTL and testbench

ALU_CHAIN_SEQ -- requirements
Module: alu_chain_seq

---
 rtl/alu_chain_seq.sv | 184 ++++++++++++++++++
 tb/tb_alu_chain_seq.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_chain_seq.sv
// Multi-byte sequencer that drives an external byte-wide ALU once per cycle and
// assembles a 1..4 byte result, chaining carry/shift bits between bytes.
module alu_chain_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_valid,
  output logic        start_ready,
  input  logic [3:0]  op,
  input  logic        xy,
  input  logic [1:0]  len,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  input  logic        cin_init,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_op,
  output logic        alu_xy,
  output logic        alu_cin,
  input  logic [7:0]  alu_q,
  input  logic        alu_cout,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] result,
  output logic        cout_final,
  output logic        zero
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic        xy_q, xy_d;
  logic [1:0]  len_q, len_d;
  logic [31:0] opa_q, opa_d, opb_q, opb_d;
  logic        cin_init_q, cin_init_d;
  logic [31:0] result_q, result_d;
  logic        cout_final_q, cout_final_d;
  logic [2:0]  k_q, k_d;
  logic        drv_q, drv_d;
  logic [1:0]  drv_idx_q, drv_idx_d;
  logic        drv_last_q, drv_last_d;
  logic [7:0]  alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [3:0]  alu_op_q, alu_op_d;
  logic        alu_xy_q, alu_xy_d;
  logic        alu_cin_q, alu_cin_d;

  logic        shr;
  logic [1:0]  issue_idx;
  logic [3:0]  chain_op;

  // Shift-right walks from the top byte down so the shifted-out bit feeds the next lower byte.
  assign shr       = (op_q[3:2] == 2'b11);
  assign issue_idx = shr ? (len_q - k_q[1:0]) : k_q[1:0];

  always_comb begin
    chain_op = op_q;
    case (op_q[3:2])
      2'b01:   chain_op = {2'b01, op_q[1], 1'b1};
      2'b10,
      2'b11:   chain_op = {op_q[3:2], 2'b01};
      default: chain_op = op_q;
    endcase
  end

  // The ALU-facing outputs come from flops: a byte is issued on one edge and its
  // combinational answer is captured on the next, so RUN spends one extra staging cycle.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    xy_d         = xy_q;
    len_d        = len_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    cin_init_d   = cin_init_q;
    result_d     = result_q;
    cout_final_d = cout_final_q;
    k_d          = k_q;
    drv_d        = 1'b0;
    drv_idx_d    = drv_idx_q;
    drv_last_d   = 1'b0;
    alu_a_d      = 8'h00;
    alu_b_d      = 8'h00;
    alu_op_d     = 4'h0;
    alu_xy_d     = 1'b0;
    alu_cin_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_valid) begin
          state_d      = RUN;
          op_d         = op;
          xy_d         = xy;
          len_d        = len;
          opa_d        = opa;
          opb_d        = opb;
          cin_init_d   = cin_init;
          result_d     = 32'h0;
          cout_final_d = 1'b0;
          k_d          = 3'd0;
        end
      end
      RUN: begin
        if (drv_q) begin
          result_d[{drv_idx_q, 3'b000} +: 8] = alu_q;
          if (drv_last_q) begin
            cout_final_d = alu_cout;
            state_d      = DONE;
          end
        end
        if (k_q <= {1'b0, len_q}) begin
          drv_d      = 1'b1;
          drv_idx_d  = issue_idx;
          drv_last_d = (k_q[1:0] == len_q);
          alu_a_d    = opa_q[{issue_idx, 3'b000} +: 8];
          alu_b_d    = opb_q[{issue_idx, 3'b000} +: 8];
          alu_op_d   = (k_q == 3'd0) ? op_q : chain_op;
          alu_cin_d  = (k_q == 3'd0) ? cin_init_q : alu_cout;
          alu_xy_d   = xy_q;
          k_d        = k_q + 3'd1;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      op_q         <= 4'h0;
      xy_q         <= 1'b0;
      len_q        <= 2'd0;
      opa_q        <= 32'h0;
      opb_q        <= 32'h0;
      cin_init_q   <= 1'b0;
      result_q     <= 32'h0;
      cout_final_q <= 1'b0;
      k_q          <= 3'd0;
      drv_q        <= 1'b0;
      drv_idx_q    <= 2'd0;
      drv_last_q   <= 1'b0;
      alu_a_q      <= 8'h00;
      alu_b_q      <= 8'h00;
      alu_op_q     <= 4'h0;
      alu_xy_q     <= 1'b0;
      alu_cin_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      xy_q         <= xy_d;
      len_q        <= len_d;
      opa_q        <= opa_d;
      opb_q        <= opb_d;
      cin_init_q   <= cin_init_d;
      result_q     <= result_d;
      cout_final_q <= cout_final_d;
      k_q          <= k_d;
      drv_q        <= drv_d;
      drv_idx_q    <= drv_idx_d;
      drv_last_q   <= drv_last_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      alu_xy_q     <= alu_xy_d;
      alu_cin_q    <= alu_cin_d;
    end
  end

  assign start_ready = (state_q == IDLE);
  assign res_valid   = (state_q == DONE);
  assign result      = result_q;
  assign cout_final  = cout_final_q;
  assign zero        = (result_q == 32'h0);
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_op      = alu_op_q;
  assign alu_xy      = alu_xy_q;
  assign alu_cin     = alu_cin_q;

endmodule

// File: tb/tb_alu_chain_seq.sv
// Directed bench for alu_chain_seq with a behavioural byte ALU closing the loop.
module tb_alu_chain_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_valid, start_ready;
  logic [3:0]  op;
  logic        xy;
  logic [1:0]  len;
  logic [31:0] opa, opb;
  logic        cin_init;
  logic [7:0]  alu_a, alu_b, alu_q;
  logic [3:0]  alu_op;
  logic        alu_xy, alu_cin, alu_cout;
  logic        res_valid, res_ready;
  logic [31:0] result;
  logic        cout_final, zero;

  int checks = 0;
  int errors = 0;

  logic [7:0] s_a   [0:31];
  logic [3:0] s_op  [0:31];
  logic       s_cin [0:31];
  logic       s_xy  [0:31];
  int         lat;

  always #5 clk = ~clk;

  alu_chain_seq dut (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
    .op(op), .xy(xy), .len(len), .opa(opa), .opb(opb), .cin_init(cin_init),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_xy(alu_xy), .alu_cin(alu_cin),
    .alu_q(alu_q), .alu_cout(alu_cout), .res_valid(res_valid), .res_ready(res_ready),
    .result(result), .cout_final(cout_final), .zero(zero)
  );

  // Byte ALU: 00 logic, 01 add/sub (op[0] uses carry, sub reports borrow), 10 shl, 11 shr.
  logic [8:0] alu_t;
  logic [7:0] alu_bb;
  logic       alu_sin;
  always_comb begin
    alu_q    = 8'h00;
    alu_cout = 1'b0;
    alu_t    = 9'h000;
    alu_bb   = alu_xy ? ~alu_b : alu_b;
    case (alu_op[1:0])
      2'b00:   alu_sin = 1'b0;
      2'b01:   alu_sin = alu_cin;
      2'b10:   alu_sin = 1'b1;
      default: alu_sin = alu_a[7];
    endcase
    case (alu_op[3:2])
      2'b00: begin
        case (alu_op[1:0])
          2'b00:   alu_q = alu_a & alu_bb;
          2'b01:   alu_q = alu_a | alu_bb;
          2'b10:   alu_q = alu_a ^ alu_bb;
          default: alu_q = alu_bb;
        endcase
      end
      2'b01: begin
        if (!alu_op[1]) alu_t = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_op[0] & alu_cin};
        else            alu_t = {1'b0, alu_a} - {1'b0, alu_b} - {8'h00, alu_op[0] & alu_cin};
        alu_q    = alu_t[7:0];
        alu_cout = alu_t[8];
      end
      2'b10: begin
        alu_q    = {alu_a[6:0], alu_sin};
        alu_cout = alu_a[7];
      end
      default: begin
        alu_q    = {alu_sin, alu_a[7:1]};
        alu_cout = alu_a[0];
      end
    endcase
  end

  // Issues one request, scrambles inputs after acceptance, records ALU drive per cycle.
  task automatic run_op(input logic [3:0] o, input logic x, input logic [1:0] l,
                        input logic [31:0] a, input logic [31:0] b, input logic ci);
    @(negedge clk);
    op = o; xy = x; len = l; opa = a; opb = b; cin_init = ci; start_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    op = 4'hA; xy = ~x; len = ~l; opa = ~a; opb = ~b; cin_init = ~ci;
    lat = 0;
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      s_a[i] = alu_a; s_op[i] = alu_op; s_cin[i] = alu_cin; s_xy[i] = alu_xy;
      if (res_valid) begin
        lat = i;
        break;
      end
    end
    $display("txn op=%b len=%0d opa=%h opb=%h cin=%b -> result=%h cout=%b zero=%b lat=%0d",
             o, l, a, b, ci, result, cout_final, zero, lat);
  endtask

  task automatic finish_txn();
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_valid = 1'b0; res_ready = 1'b0;
    op = 4'h0; xy = 1'b0; len = 2'd0; opa = 32'h0; opb = 32'h0; cin_init = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (start_ready !== 1'b1) begin errors++; $display("FAIL reset_start_ready got %b exp 1", start_ready); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %b exp 0", res_valid); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got %h exp 0", result); end
    checks++; if (cout_final !== 1'b0) begin errors++; $display("FAIL reset_cout got %b exp 0", cout_final); end
    checks++; if (zero !== 1'b1) begin errors++; $display("FAIL reset_zero got %b exp 1", zero); end
    checks++; if ({alu_a, alu_b, alu_op, alu_xy, alu_cin} !== 22'h0) begin errors++;
      $display("FAIL reset_alu got %h exp 0", {alu_a, alu_b, alu_op, alu_xy, alu_cin}); end
    rst_n = 1'b1;
    $display("txn reset released");
  endtask

  task automatic test_add16();
    run_op(4'b0100, 1'b0, 2'd1, 32'h000000FF, 32'h00000001, 1'b0);
    checks++; if (lat !== 3) begin errors++; $display("FAIL add16_latency got %0d exp 3", lat); end
    checks++; if (result !== 32'h00000100) begin errors++; $display("FAIL add16_result got %h exp 00000100", result); end
    checks++; if ({cout_final, zero} !== 2'b00) begin errors++; $display("FAIL add16_flags got %b exp 00", {cout_final, zero}); end
    checks++; if ({s_op[1], s_op[2]} !== 8'h45) begin errors++; $display("FAIL add16_alu_op got %h exp 45", {s_op[1], s_op[2]}); end
    checks++; if ({s_cin[1], s_cin[2]} !== 2'b01) begin errors++; $display("FAIL add16_alu_cin got %b exp 01", {s_cin[1], s_cin[2]}); end
    checks++; if ({alu_a, alu_op} !== 12'h0) begin errors++; $display("FAIL add16_done_alu got %h exp 0", {alu_a, alu_op}); end
    finish_txn();
    checks++; if ({start_ready, res_valid} !== 2'b10) begin errors++; $display("FAIL add16_handshake got %b exp 10", {start_ready, res_valid}); end
  endtask

  task automatic test_sub32();
    run_op(4'b0110, 1'b0, 2'd3, 32'h00000000, 32'h00000001, 1'b0);
    checks++; if (lat !== 5) begin errors++; $display("FAIL sub32_latency got %0d exp 5", lat); end
    checks++; if (result !== 32'hFFFFFFFF) begin errors++; $display("FAIL sub32_result got %h exp FFFFFFFF", result); end
    checks++; if ({cout_final, zero} !== 2'b10) begin errors++; $display("FAIL sub32_flags got %b exp 10", {cout_final, zero}); end
    checks++; if ({s_op[1], s_op[2], s_op[4]} !== 12'h677) begin errors++;
      $display("FAIL sub32_alu_op got %h exp 677", {s_op[1], s_op[2], s_op[4]}); end
    finish_txn();
  endtask

  task automatic test_shl24();
    run_op(4'b1001, 1'b0, 2'd2, 32'h00800001, 32'h00000000, 1'b0);
    checks++; if (result !== 32'h00000002) begin errors++; $display("FAIL shl24_result got %h exp 00000002", result); end
    checks++; if (cout_final !== 1'b1) begin errors++; $display("FAIL shl24_cout got %b exp 1", cout_final); end
    checks++; if ({s_a[1], s_a[2], s_a[3]} !== 24'h010080) begin errors++;
      $display("FAIL shl24_alu_a_seq got %h exp 010080", {s_a[1], s_a[2], s_a[3]}); end
    checks++; if ({s_op[1], s_op[2], s_op[3]} !== 12'h999) begin errors++;
      $display("FAIL shl24_alu_op got %h exp 999", {s_op[1], s_op[2], s_op[3]}); end
    finish_txn();
  endtask

  task automatic test_sar16();
    run_op(4'b1111, 1'b0, 2'd1, 32'h00008002, 32'h00000000, 1'b0);
    checks++; if (result !== 32'h0000C001) begin errors++; $display("FAIL sar16_result got %h exp 0000C001", result); end
    checks++; if (cout_final !== 1'b0) begin errors++; $display("FAIL sar16_cout got %b exp 0", cout_final); end
    checks++; if ({s_a[1], s_a[2]} !== 16'h8002) begin errors++; $display("FAIL sar16_alu_a_seq got %h exp 8002", {s_a[1], s_a[2]}); end
    checks++; if ({s_op[1], s_op[2]} !== 8'hFD) begin errors++; $display("FAIL sar16_alu_op got %h exp FD", {s_op[1], s_op[2]}); end
    finish_txn();
  endtask

  // Single byte: upper operand bytes must be ignored and xy forwarded.
  task automatic test_len0();
    run_op(4'b0101, 1'b1, 2'd0, 32'h123456FF, 32'h00000000, 1'b1);
    checks++; if (lat !== 2) begin errors++; $display("FAIL len0_latency got %0d exp 2", lat); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL len0_result got %h exp 0", result); end
    checks++; if ({cout_final, zero} !== 2'b11) begin errors++; $display("FAIL len0_flags got %b exp 11", {cout_final, zero}); end
    checks++; if ({s_xy[1], s_cin[1]} !== 2'b11) begin errors++; $display("FAIL len0_xy_cin got %b exp 11", {s_xy[1], s_cin[1]}); end
    finish_txn();
  endtask

  task automatic test_backpressure();
    int bad;
    run_op(4'b0100, 1'b0, 2'd0, 32'h00000022, 32'h00000011, 1'b0);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      op = 4'b0110; len = 2'd3; opa = 32'hDEADBEEF; opb = 32'h1; start_valid = (i % 2 == 0);
      @(negedge clk);
      if (result !== 32'h00000033 || start_ready !== 1'b0 || res_valid !== 1'b1) bad++;
    end
    start_valid = 1'b0;
    checks++; if (bad !== 0) begin errors++; $display("FAIL backpressure_hold got %0d bad cycles exp 0", bad); end
    finish_txn();
    repeat (3) @(negedge clk);
    checks++; if ({start_ready, res_valid, result} !== {2'b10, 32'h00000033}) begin errors++;
      $display("FAIL backpressure_no_accept got %b/%h exp 10/00000033", {start_ready, res_valid}, result); end
  endtask

  task automatic test_reset_mid_run();
    int seen;
    @(negedge clk);
    op = 4'b0100; xy = 1'b0; len = 2'd3; opa = 32'h01010101; opb = 32'h01010101; cin_init = 1'b0; start_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if ({start_ready, res_valid} !== 2'b10) begin errors++; $display("FAIL rst_run_state got %b exp 10", {start_ready, res_valid}); end
    checks++; if ({result, zero} !== {32'h0, 1'b1}) begin errors++; $display("FAIL rst_run_result got %h/%b exp 0/1", result, zero); end
    checks++; if ({alu_a, alu_op, alu_cin} !== 13'h0) begin errors++; $display("FAIL rst_run_alu got %h exp 0", {alu_a, alu_op, alu_cin}); end
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (res_valid) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rst_run_no_valid got %0d exp 0", seen); end
    $display("txn reset mid-run aborted");
  endtask

  initial begin
    test_reset();
    test_add16();
    test_sub32();
    test_shl24();
    test_sar16();
    test_len0();
    test_backpressure();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
